// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between REQUESTERS blocks.
// Round-robin grant, one transaction in flight, fixed-latency reads.
// Optional build macro: ARB_WRITE_PRIORITY_EN (drain pending writes before
// any load is considered; the round-robin pointer stays shared).
//
// Handshake: req_load/req_write are level requests. A requester raises one or
// both with stable req_addr/req_wdata and holds them until its ack bit pulses
// for one cycle, then drops the served request the following cycle. Requests
// are sampled only in IDLE. mem_load/mem_write are single-cycle strobes that
// qualify mem_addr/mem_wdata; there is no back-pressure from memory.
module mem_port_arbiter #(
   parameter int REQUESTERS   = 4,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 512,
   parameter int READ_LATENCY = 2,
   localparam int GW          = $clog2(REQUESTERS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [REQUESTERS-1:0]        req_load,
   input  logic [REQUESTERS-1:0]        req_write,
   input  logic [REQUESTERS*ADDR_W-1:0] req_addr,
   input  logic [REQUESTERS*DATA_W-1:0] req_wdata,
   output logic [REQUESTERS-1:0]        ack,
   output logic [DATA_W-1:0]            rdata,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic                         mem_load,
   output logic                         mem_write,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         busy,
   output logic [GW-1:0]                grant_id
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   // Counter only needs to hold READ_LATENCY-1.
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT  = CW'(READ_LATENCY - 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(REQUESTERS - 1);

   logic [1:0]            state;
   logic [GW-1:0]         last_grant;
   logic [CW-1:0]         cnt;
   logic                  op_write;
   logic [REQUESTERS-1:0] cand;
   logic                  pick_found;
   logic [GW-1:0]         pick_idx;
   logic [GW-1:0]         scan_idx;
   int                    scan;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic                  sel_write;
   logic [REQUESTERS-1:0] grant_onehot;

   // Candidate set for the round-robin search.
`ifdef ARB_WRITE_PRIORITY_EN
   assign cand = (|req_write) ? req_write : (req_load | req_write);
`else
   assign cand = req_load | req_write;
`endif

   // Round-robin search: first candidate after last_grant, wrapping to 0.
   // Scanning from the farthest offset down lets the nearest hit win.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan       = 0;
      scan_idx   = '0;
      for (int k = REQUESTERS; k >= 1; k--) begin
         scan = int'(last_grant) + k;
         if (scan >= REQUESTERS) scan = scan - REQUESTERS;
         scan_idx = GW'(scan);
         if (cand[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Address, data and operation of the requester chosen above; write wins
   // when a requester asks for both.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (pick_idx == GW'(i)) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_write = req_write[i];
         end
      end
   end

   // One-hot ack vector for the requester currently being served.
   always_comb begin
      grant_onehot = '0;
      grant_onehot[grant_id] = 1'b1;
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= LAST_INIT;
         cnt        <= '0;
         op_write   <= 1'b0;
         ack        <= '0;
         rdata      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_load   <= 1'b0;
         mem_write  <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  state      <= S_ISSUE;
                  grant_id   <= pick_idx;
                  last_grant <= pick_idx;
                  op_write   <= sel_write;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_write  <= sel_write;
                  mem_load   <= ~sel_write;
                  busy       <= 1'b1;
               end
            end
            S_ISSUE: begin
               mem_write <= 1'b0;
               mem_load  <= 1'b0;
               if (op_write) begin
                  state <= S_ACK;
                  ack   <= grant_onehot;
               end else begin
                  state <= S_WAIT;
                  cnt   <= CNT_INIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  rdata <= mem_rdata;
                  state <= S_ACK;
                  ack   <= grant_onehot;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_ACK: begin
               ack   <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one main-memory port between REQUESTERS processing blocks. Each block issues load or write requests using its load/write control, address and data signals.
- Round-robin arbitration; one transaction in flight at a time; fixed-latency memory reads.
- Returns a one-cycle ack per completed transaction. Read data is held on a shared return bus.
- Sits between the processing-block array and main memory.

Parameters:
- REQUESTERS, 4, number of processing blocks sharing the port (≥2)
- ADDR_W, 16, main-memory address width
- DATA_W, 512, data width (CORES*BITS of a processing block)
- READ_LATENCY, 2, cycles from mem_load issue to mem_rdata valid (≥1)
- localparam GW = $clog2(REQUESTERS)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_load  in  REQUESTERS  bit i: requester i wants a load; level, held until ack[i]
- req_write  in  REQUESTERS  bit i: requester i wants a write; level, held until ack[i]
- req_addr  in  REQUESTERS*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
- req_wdata  in  REQUESTERS*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
- ack  out  REQUESTERS  one-cycle pulse: requester i transaction complete
- rdata  out  DATA_W  load data; valid while ack is high, held until next load capture
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_load  out  1  one-cycle memory read strobe
- mem_write  out  1  one-cycle memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE
- grant_id  out  GW  index of the requester currently being served

Behaviour:
- Interface: one clock, "clock"; reset "reset" is synchronous and active-high.
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, last_grant = REQUESTERS-1 (requester 0 wins first), read counter 0.
- States:
  - IDLE: pending[i] = req_load[i] | req_write[i]. If any bit is set, pick the first pending index searching last_grant+1 upward with wrap to 0. Latch grant_id, address, write data and op (write if req_write[i], else load). Update last_grant. Go to ISSUE.
  - ISSUE (1 cycle): drive mem_addr and mem_wdata from the latched values. Assert mem_write (write) or mem_load (load) for exactly this cycle. Write -> ACK. Load -> WAIT with counter = READ_LATENCY-1.
  - WAIT: decrement the counter. When the counter is 0, capture mem_rdata into rdata and go to ACK. WAIT lasts exactly READ_LATENCY cycles.
  - ACK (1 cycle): ack[grant_id] = 1, all other ack bits 0. Next state IDLE.
- Latency, request first seen in IDLE at cycle t:
  - write: strobe at t+1, ack at t+2
  - load: strobe at t+1, ack at t+2+READ_LATENCY
- Requester protocol: hold req_*, req_addr and req_wdata stable until ack. Drop the request the cycle after ack. The arbiter does not sample requests in ISSUE, WAIT or ACK.
- If both req_load[i] and req_write[i] are high, the write is served and the load stays pending for a later grant.
- Fairness: while all requesters are pending, grants rotate 0,1,2,...,REQUESTERS-1,0.
- Requests that arrive during a transaction wait until the next IDLE. There is no back-to-back issue, so the minimum gap is one IDLE cycle.
- Reset mid-transaction: abort immediately and return to reset values. No ack is issued for the aborted transaction. A memory write already strobed is not undone.
- mem_addr and mem_wdata hold their last values outside ISSUE. Only the strobes qualify them.

Optional Feature:
- Macro: ARB_WRITE_PRIORITY_EN.
- Defined: in IDLE, if any req_write bit is set, round-robin runs over req_write only, still using the shared last_grant. Loads are considered only when no write is pending. This drains writes before dependent loads.
- Undefined: unified round-robin over req_load | req_write, as described above.

Test Plan:
- Single write: reset, then req_write[2]=1, addr 0x0040, wdata pattern A -> mem_write pulse at t+1 with addr 0x0040 and data A; ack=4'b0100 at t+2; busy high for t+1..t+2.
- Single load, READ_LATENCY=2: req_load[1], addr 0x1234; memory model returns B at issue+2 -> mem_load at t+1; ack=4'b0010 at t+4; rdata=B in that cycle and held afterwards.
- All four requesters hold loads continuously -> grant order 0,1,2,3,0; each ack exactly once per round; no requester served twice before all others.
- Requester 3 asserts both load and write -> write served first; load served on a later grant; two separate acks.
- Reset asserted during WAIT of a load -> no ack; all outputs 0 next cycle; next grant goes to requester 0.
- With ARB_WRITE_PRIORITY_EN: req_load[0] and req_write[2] pending together -> requester 2 served first; without the macro, requester 0 is served first.
